// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding selects and load-use stall
// control for a 5-stage pipeline. A private shadow of the ID/EX, EX/MEM and
// MEM/WB register-address/control fields is kept here, so the unit needs
// only the ID-stage decode plus the branch flush.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // ID/EX shadow
  logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic              r_ex_regwrite, r_ex_memread;
  // EX/MEM shadow
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite, r_mem_memread;
  // MEM/WB shadow
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_haz;
  logic              w_stall;
  logic              w_bubble;

  // Youngest-producer-wins select for one operand. A load sitting in MEM has
  // no data yet, so it is skipped and the operand falls through to MEM/WB
  // (which then carries the loaded value one cycle later).
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_rw,
    input logic              mem_ld,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_rw
  );
    fwd_sel = 2'b00;
    if (mem_rw && !mem_ld && (mem_rd != '0) && (mem_rd == rs))
      fwd_sel = 2'b10;
    else if (wb_rw && (wb_rd != '0) && (wb_rd == rs))
      fwd_sel = 2'b01;
  endfunction

  // Load-use detection: the load in EX cannot feed the ID instruction in
  // time. A flush kills the ID instruction, so it never stalls.
  always_comb begin
    w_haz    = id_valid_i && r_ex_memread && (r_ex_rd != '0) &&
               ((r_ex_rd == id_rs1_i) || (r_ex_rd == id_rs2_i));
    w_stall  = w_haz && !flush_i;
    w_bubble = flush_i || w_stall || !id_valid_i;
  end

  // Operand mux selects depend on shadow state only (no input-to-output path).
  always_comb begin
    fwd_a_o = fwd_sel(r_ex_rs1, r_mem_rd, r_mem_regwrite, r_mem_memread,
                      r_wb_rd, r_wb_regwrite);
    fwd_b_o = fwd_sel(r_ex_rs2, r_mem_rd, r_mem_regwrite, r_mem_memread,
                      r_wb_rd, r_wb_regwrite);
  end

  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

  // Shadow pipeline advance; a bubble (all zero) enters EX on flush/stall/idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;
      if (w_bubble) begin
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_rs1      <= id_rs1_i;
        r_ex_rs2      <= id_rs2_i;
        r_ex_rd       <= id_rd_i;
        r_ex_regwrite <= id_regwrite_i;
        r_ex_memread  <= id_memread_i;
      end
    end
  end

  // Saturating count of stall cycles; holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// checked against an instruction-history model. A second instance with a
// 2-bit counter shares all inputs to exercise saturation.
module tb_fwd_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_regwrite_i, id_memread_i, flush_i;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;
  logic [1:0]  fwd_a2, fwd_b2;
  logic        stall2;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2),
    .stall_o(stall2), .stall_cnt_o(stall_cnt2)
  );

  // Reference model: hist[0] is the instruction in EX, hist[1] the one
  // issued before it (now in MEM), hist[2] the one before that (in WB).
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       wr, ld;
  } ins_t;

  ins_t        hist [3];
  logic [31:0] m_cnt;
  int          m_cnt2;

  // Nearest older producer of rs wins; a load one slot ahead has no data yet.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    m_fwd = 2'b00;
    for (int d = 2; d >= 1; d--)
      if (hist[d].wr && hist[d].rd != 5'd0 && hist[d].rd == rs && !(d == 1 && hist[d].ld))
        m_fwd = (d == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic m_stall();
    m_stall = id_valid_i && hist[0].ld && hist[0].rd != 5'd0 &&
              (hist[0].rd == id_rs1_i || hist[0].rd == id_rs2_i) && !flush_i;
  endfunction

  task automatic model_edge();
    logic st;
    if (rst_i) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      st = m_stall();
      if (st) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (flush_i || st || !id_valid_i) hist[0] = '0;
      else hist[0] = '{rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                       wr: id_regwrite_i, ld: id_memread_i};
    end
  endtask

  // Inputs change at negedge; model advances on the same posedge as the DUT.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    rst_i = 1'b0; id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) begin
      id_valid_i = 1'b1; id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom);
      id_rd_i = 5'($urandom); id_regwrite_i = 1'($urandom);
      id_memread_i = 1'($urandom); flush_i = 1'($urandom);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_o); end
    n_checks++; if (fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    n_checks++; if (stall_cnt_o !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
    n_checks++; if (stall_cnt2 !== 2'd0) begin n_errors++; $display("FAIL reset_cnt2: got %0d want 0", stall_cnt2); end
  endtask

  task automatic test_exmem_fwd();
    drv(1, 1, 2, 5, 1, 0, 0); tick();   // add x5
    drv(1, 5, 5, 6, 1, 0, 0); tick();   // sub x6, x5, x5
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_a_o !== 2'b10) begin n_errors++; $display("FAIL exmem_fwd_a: got %b want 10", fwd_a_o); end
    n_checks++; if (fwd_b_o !== 2'b10) begin n_errors++; $display("FAIL exmem_fwd_b: got %b want 10", fwd_b_o); end
  endtask

  task automatic test_priority();
    drv(1, 1, 2, 7, 1, 0, 0); tick();
    drv(1, 3, 4, 7, 1, 0, 0); tick();
    drv(1, 8, 7, 9, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_b_o !== 2'b10) begin n_errors++; $display("FAIL prio_young_b: got %b want 10", fwd_b_o); end
    n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL prio_young_a: got %b want 00", fwd_a_o); end
    drv(1, 1, 2, 7, 1, 0, 0); tick();
    drv(1, 1, 2, 10, 1, 0, 0); tick();
    drv(1, 0, 7, 11, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_b_o !== 2'b01) begin n_errors++; $display("FAIL prio_gap_b: got %b want 01", fwd_b_o); end
    n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL prio_gap_a: got %b want 00", fwd_a_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    drv(1, 1, 2, 3, 1, 1, 0); tick();   // lw x3
    drv(1, 3, 4, 8, 1, 0, 0); #1;       // add x8, x3, x4
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL lu_stall_on: got %b want 1", stall_o); end
    n_checks++; if (stall_cnt_o !== 32'd0) begin n_errors++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt_o); end
    tick(); #1;                          // add held in ID
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL lu_stall_off: got %b want 0", stall_o); end
    n_checks++; if (stall_cnt_o !== 32'd1) begin n_errors++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt_o); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_a_o !== 2'b01) begin n_errors++; $display("FAIL lu_fwd_a: got %b want 01", fwd_a_o); end
    n_checks++; if (stall_cnt_o !== 32'd1) begin n_errors++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt_o); end
  endtask

  task automatic test_flush();
    do_reset();
    drv(1, 1, 2, 3, 1, 1, 0); tick();
    drv(1, 3, 4, 8, 1, 0, 1); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL flush_stall: got %b want 0", stall_o); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (stall_cnt_o !== 32'd0) begin n_errors++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt_o); end
    n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL flush_bubble_a: got %b want 00", fwd_a_o); end
    // the load now in MEM must not feed the bubble nor the next user via EX/MEM
    drv(1, 3, 3, 9, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_a_o !== 2'b01) begin n_errors++; $display("FAIL flush_load_wb: got %b want 01", fwd_a_o); end
  endtask

  task automatic test_x0();
    drv(1, 1, 2, 0, 1, 0, 0); tick();
    drv(1, 0, 0, 4, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); #1;
    n_checks++; if (fwd_a_o !== 2'b00) begin n_errors++; $display("FAIL x0_fwd_a: got %b want 00", fwd_a_o); end
    n_checks++; if (fwd_b_o !== 2'b00) begin n_errors++; $display("FAIL x0_fwd_b: got %b want 00", fwd_b_o); end
    drv(1, 1, 2, 0, 1, 1, 0); tick();
    drv(1, 0, 0, 4, 1, 0, 0); #1;
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL x0_load_stall: got %b want 0", stall_o); end
    tick();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 2, 3, 1, 1, 0); tick();
      drv(1, 3, 3, 8, 1, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0, 0); tick(); #1;
      want = (i + 1 > 3) ? 3 : i + 1;
      n_checks++; if (stall_cnt2 !== 2'(want)) begin n_errors++; $display("FAIL sat_cnt2_%0d: got %0d want %0d", i, stall_cnt2, want); end
    end
    n_checks++; if (stall_cnt_o !== 32'd5) begin n_errors++; $display("FAIL sat_cnt32: got %0d want 5", stall_cnt_o); end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    logic       es;
    for (int c = 0; c < 600; c++) begin
      rst_i         = ($urandom_range(0, 99) == 0);
      id_valid_i    = ($urandom_range(0, 9) != 0);
      id_rs1_i      = 5'($urandom_range(0, 7));
      id_rs2_i      = 5'($urandom_range(0, 7));
      id_rd_i       = 5'($urandom_range(0, 7));
      id_regwrite_i = ($urandom_range(0, 3) != 0);
      id_memread_i  = ($urandom_range(0, 2) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      #1;
      ea = m_fwd(hist[0].rs1);
      eb = m_fwd(hist[0].rs2);
      es = m_stall();
      n_checks++; if (fwd_a_o !== ea) begin n_errors++; $display("FAIL rnd_fwd_a c%0d: got %b want %b", c, fwd_a_o, ea); end
      n_checks++; if (fwd_b_o !== eb) begin n_errors++; $display("FAIL rnd_fwd_b c%0d: got %b want %b", c, fwd_b_o, eb); end
      n_checks++; if (stall_o !== es) begin n_errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_o, es); end
      n_checks++; if (stall_cnt_o !== m_cnt) begin n_errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt_o, m_cnt); end
      n_checks++; if (stall_cnt2 !== 2'(m_cnt2)) begin n_errors++; $display("FAIL rnd_cnt2 c%0d: got %0d want %0d", c, stall_cnt2, m_cnt2); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    m_cnt = 0; m_cnt2 = 0;
    rst_i = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    test_reset();
    test_exmem_fwd();
    test_priority();
    test_load_use();
    test_flush();
    test_x0();
    test_saturation();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
